inv_bvult_bvmul_ctrl: RTL
=========================

// Module: inv_bvult_bvmul_ctrl
// PURPOSE
//  Sequencer around the combinational Skolem function for "exists x: (x*s) <u t" (W-bit bvmul/bvult).
//  Per request it latches s/t, presents them to the external Skolem block and captures its candidate x.
//  It then checks x*s <u t on a shared shift-add multiplier.
//  If the check fails, it falls back to an exhaustive search and returns a certified witness or "no solution".
//  Sits between the benchmark harness/driver and the Skolem netlist; counts Skolem failures for regression stats.
// PARAMETERS
//  W        4   bit-width of s, t, x (Skolem netlist is generated for W=4)
//  CNT_W    8   width of saturating fallback-event counter
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      synchronous, active-high reset
//  in_valid      in   1      request valid
//  in_ready      out  1      request accepted when in_valid & in_ready
//  s_in          in   W      operand s
//  t_in          in   W      bound t
//  sk_s          out  W      s driven to Skolem netlist (registered)
//  sk_t          out  W      t driven to Skolem netlist (registered)
//  sk_x          in   W      Skolem candidate x (combinational function of sk_s/sk_t)
//  out_valid     out  1      result valid; held until out_ready
//  out_ready     in   1      result consumed when out_valid & out_ready
//  x_out         out  W      certified witness (0 when found=0)
//  found         out  1      1: x_out*s <u t holds; 0: no x exists (t==0)
//  used_fallback out  1      1: Skolem candidate failed the check and search produced result
//  fail_cnt      out  CNT_W  saturating count of requests where Skolem candidate failed
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; x_out=0; found=0; used_fallback=0; sk_s=sk_t=0; fail_cnt=0.
//  Reset mid-operation aborts the request; no output is produced for it.
//  States: IDLE -> SKOLEM -> MUL -> CHECK -> {DONE | SEARCH_MUL -> SEARCH_CHK -> ...} -> DONE -> IDLE.
//  IDLE: in_ready=1 only here; on accept, latch s/t into sk_s/sk_t; go to SKOLEM.
//  SKOLEM (1 cyc): register cand<=sk_x; go to MUL.
//  MUL (W cyc): LSB-first shift-add of cand*s, product truncated mod 2^W (carries past bit W-1 dropped).
//  CHECK (1 cyc): unsigned prod <u t.
//   - Pass: x_out=cand, found=1, used_fallback=0; go to DONE.
//   - Fail: fail_cnt+=1 (saturate at 2^CNT_W-1); cand<=1; go to SEARCH_MUL.
//  SEARCH_MUL/SEARCH_CHK: same W+1-cycle multiply/compare per candidate.
//   - Candidate order: 1,2,...,2^W-1, then 0 last (cand wraps 2^W-1 -> 0).
//   - First pass: x_out=cand, found=1, used_fallback=1.
//   - Candidate 0 fails: x_out=0, found=0, used_fallback=1.
//  DONE: out_valid=1; outputs stable until out_ready; on out_valid&out_ready go to IDLE.
//   - out_valid deasserts the next cycle; in_ready reasserts the next cycle (no same-cycle turnaround).
//  Latency (accept edge to out_valid), for W=4:
//   - Skolem pass: W+3 cycles (7).
//   - Fallback hitting candidate k (k=1..2^W-1): W+3 + k*(W+1).
//   - t==0 (full wrap to 0): W+3 + 2^W*(W+1) = 87.
//  Correctness: found=1 iff t!=0 (x=0 always satisfies). Skolem output is never trusted without the CHECK.
//  in_valid while busy: ignored (in_ready=0); s_in/t_in are sampled only on acceptance.
// STRUCTURE
//  Package inv_bvult_bvmul_pkg:
//   - state_e enum (IDLE, SKOLEM, MUL, CHECK, SEARCH_MUL, SEARCH_CHK, DONE).
//   - W default; shared cycle-count helper constants.
//  Sub-module bv_shift_add_mul:
//   - Ports: start, multiplicand, multiplier, busy, done, prod (W-bit truncated).
//   - One multiplier instance shared by the MUL and SEARCH_MUL states.
//  Skolem netlist is instantiated outside this block, by the parent wrapper.
// TESTING (bench drives sk_x from the real Skolem netlist or a forcing model)
//  1. s=3,t=5, sk_x=1 -> prod=3 <5; out_valid 7 cyc after accept; x_out=1 found=1 fallback=0.
//  2. s=3,t=2, forced sk_x=5 (prod 15) -> fail_cnt=1; search: x=1 prod 3 fails, x=2 prod 6 fails, x=3 prod 9 fails,
//     x=4 prod 12 fails, x=5 prod 15 fails, x=6 prod 18 mod 16=2 fails, x=7 prod 21 mod 16=5 fails,
//     x=8 prod 24 mod 16=8 fails, x=9 prod 27 mod 16=11 fails, x=10 prod 30 mod 16=14 fails,
//     x=11 prod 33 mod 16=1 <2 passes -> x_out=11 found=1 fallback=1; out_valid at cycle 7+11*5=62.
//  3. s=9,t=0 -> full wrap 1..15 then 0; x_out=0 found=0 fallback=1; out_valid at cycle 87.
//  4. Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; in_valid pulses ignored.
//  5. rst asserted in SEARCH_MUL -> next cycle IDLE, out_valid=0, fail_cnt=0; new request completes normally.
//  6. Random sweep of all 256 (s,t) pairs vs golden model; force 2^CNT_W+3 failures -> fail_cnt saturates at 255.

Source files
------------

// File: rtl/inv_bvult_bvmul_pkg.sv
// Shared definitions for the bvmul/bvult Skolem-check sequencer.
// Contents:
//   W_DEFAULT, CNT_W_DEFAULT : default operand width and fallback-counter width
//   state_e                  : sequencer states
//   pass_latency / cand_cycles : cycle-count helpers for the accept-to-result timing
package inv_bvult_bvmul_pkg;

  localparam int W_DEFAULT     = 4;
  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    SKOLEM,
    MUL,
    CHECK,
    SEARCH_MUL,
    SEARCH_CHK,
    DONE
  } state_e;

  // Cycles from the accept edge to out_valid when the Skolem candidate passes.
  function automatic int pass_latency(input int w);
    return w + 3;
  endfunction

  // Cycles spent on each exhaustive-search candidate (multiply plus compare).
  function automatic int cand_cycles(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/inv_bvult_bvmul_ctrl_mul.sv
// bv_shift_add_mul: sequential LSB-first shift-add multiplier, product truncated to W bits.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   start        : load operands and clear the accumulator (takes priority over stepping)
//   multiplicand : operand shifted left each step
//   multiplier   : operand scanned LSB first
//   busy         : a multiply is in progress (W steps after the load)
//   done         : the final step happens this cycle; prod is valid from the next cycle
//   prod         : accumulator, (multiplicand*multiplier) mod 2^W once finished
module bv_shift_add_mul #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] multiplicand,
  input  logic [W-1:0] multiplier,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] prod
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state for the datapath: a load on start, otherwise one add/shift step
  // per cycle while steps remain. Bits shifted past W-1 are simply dropped,
  // which gives the modulo-2^W product for free.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (start) begin
      a_d   = multiplicand;
      b_d   = multiplier;
      acc_d = '0;
      cnt_d = CW'(W);
    end else if (cnt_q != '0) begin
      if (b_q[0]) begin
        acc_d = acc_q + a_q;
      end
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CW'(1));
  assign prod = acc_q;

endmodule

// File: rtl/inv_bvult_bvmul_ctrl.sv
// inv_bvult_bvmul_ctrl: sequencer around an external Skolem function for
// "exists x: (x*s) <u t". Latches s/t, captures the Skolem candidate, certifies it
// on a shared shift-add multiplier and, if it fails, searches 1..2^W-1 then 0.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : request handshake (in_ready only in IDLE)
//   s_in, t_in            : operand s and bound t, sampled on acceptance
//   sk_s, sk_t            : registered operands presented to the Skolem netlist
//   sk_x                  : Skolem candidate (combinational from sk_s/sk_t)
//   out_valid / out_ready : result handshake, result held until consumed
//   x_out, found          : certified witness, or found=0 / x_out=0 when t==0
//   used_fallback         : Skolem candidate failed and the search produced the result
//   fail_cnt              : saturating count of Skolem candidate failures
module inv_bvult_bvmul_ctrl
  import inv_bvult_bvmul_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     s_in,
  input  logic [W-1:0]     t_in,
  output logic [W-1:0]     sk_s,
  output logic [W-1:0]     sk_t,
  input  logic [W-1:0]     sk_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     x_out,
  output logic             found,
  output logic             used_fallback,
  output logic [CNT_W-1:0] fail_cnt
);

  state_e             state_q, state_d;
  logic [W-1:0]       sk_s_q, sk_s_d;
  logic [W-1:0]       sk_t_q, sk_t_d;
  logic [W-1:0]       cand_q, cand_d;
  logic [W-1:0]       x_out_q, x_out_d;
  logic               found_q, found_d;
  logic               fb_q, fb_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;

  logic               mul_start;
  logic [W-1:0]       mul_b;
  logic               mul_busy;
  logic               mul_done;
  logic [W-1:0]       mul_prod;
  logic               prod_lt_t;

  // One multiplier serves both the Skolem check and every search candidate;
  // the operand s is always the latched sk_s.
  bv_shift_add_mul #(.W(W)) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (mul_start),
    .multiplicand (sk_s_q),
    .multiplier   (mul_b),
    .busy         (mul_busy),
    .done         (mul_done),
    .prod         (mul_prod)
  );

  assign prod_lt_t = (mul_prod < sk_t_q);

  // Next-state and datapath control. Each multiply is launched in the cycle that
  // chooses the candidate, so the multiplier loads on the same edge that cand
  // is registered. out_valid lags entry into DONE by one cycle, giving the
  // result registers a settled cycle before they are presented.
  always_comb begin
    state_d     = state_q;
    sk_s_d      = sk_s_q;
    sk_t_d      = sk_t_q;
    cand_d      = cand_q;
    x_out_d     = x_out_q;
    found_d     = found_q;
    fb_d        = fb_q;
    out_valid_d = 1'b0;
    fail_cnt_d  = fail_cnt_q;
    mul_start   = 1'b0;
    mul_b       = cand_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sk_s_d  = s_in;
          sk_t_d  = t_in;
          state_d = SKOLEM;
        end
      end

      SKOLEM: begin
        cand_d    = sk_x;
        mul_start = 1'b1;
        mul_b     = sk_x;
        state_d   = MUL;
      end

      MUL: begin
        if (mul_busy && mul_done) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (prod_lt_t) begin
          x_out_d = cand_q;
          found_d = 1'b1;
          fb_d    = 1'b0;
          state_d = DONE;
        end else begin
          if (fail_cnt_q != {CNT_W{1'b1}}) begin
            fail_cnt_d = fail_cnt_q + CNT_W'(1);
          end
          cand_d    = W'(1);
          mul_start = 1'b1;
          mul_b     = W'(1);
          state_d   = SEARCH_MUL;
        end
      end

      SEARCH_MUL: begin
        if (mul_busy && mul_done) begin
          state_d = SEARCH_CHK;
        end
      end

      SEARCH_CHK: begin
        if (prod_lt_t) begin
          x_out_d = cand_q;
          found_d = 1'b1;
          fb_d    = 1'b1;
          state_d = DONE;
        end else if (cand_q == '0) begin
          // Zero is tried last; if even x=0 fails then t==0 and no witness exists.
          x_out_d = '0;
          found_d = 1'b0;
          fb_d    = 1'b1;
          state_d = DONE;
        end else begin
          cand_d    = cand_q + W'(1);
          mul_start = 1'b1;
          mul_b     = cand_q + W'(1);
          state_d   = SEARCH_MUL;
        end
      end

      DONE: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; a reset at any point abandons the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sk_s_q      <= '0;
      sk_t_q      <= '0;
      cand_q      <= '0;
      x_out_q     <= '0;
      found_q     <= 1'b0;
      fb_q        <= 1'b0;
      out_valid_q <= 1'b0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sk_s_q      <= sk_s_d;
      sk_t_q      <= sk_t_d;
      cand_q      <= cand_d;
      x_out_q     <= x_out_d;
      found_q     <= found_d;
      fb_q        <= fb_d;
      out_valid_q <= out_valid_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign sk_s          = sk_s_q;
  assign sk_t          = sk_t_q;
  assign out_valid     = out_valid_q;
  assign x_out         = x_out_q;
  assign found         = found_q;
  assign used_fallback = fb_q;
  assign fail_cnt      = fail_cnt_q;

endmodule
